// File: rtl/ram_1p_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit RAM between several req/gnt hosts.
// Out-of-range accesses are granted but answered locally with an error response.
module ram_1p_arbiter #(
   parameter int NumHosts = 2,
   parameter int Depth    = 128
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NumHosts-1:0]        host_req_i,
   output logic [NumHosts-1:0]        host_gnt_o,
   input  logic [NumHosts-1:0]        host_we_i,
   input  logic [NumHosts-1:0][3:0]   host_be_i,
   input  logic [NumHosts-1:0][31:0]  host_addr_i,
   input  logic [NumHosts-1:0][31:0]  host_wdata_i,
   output logic [NumHosts-1:0]        host_rvalid_o,
   output logic [NumHosts-1:0][31:0]  host_rdata_o,
   output logic [NumHosts-1:0]        host_err_o,
   output logic                       ram_req_o,
   output logic                       ram_we_o,
   output logic [3:0]                 ram_be_o,
   output logic [31:0]                ram_addr_o,
   output logic [31:0]                ram_wdata_o,
   input  logic                       ram_rvalid_i,
   input  logic [31:0]                ram_rdata_i
);

   localparam int Aw   = $clog2(Depth);
   localparam int IdxW = $clog2(NumHosts);

   logic [IdxW-1:0] rr_ptr_q;
   logic [IdxW-1:0] rr_ptr_d;
   logic [IdxW-1:0] gnt_idx;
   logic [IdxW-1:0] cand;
   logic [IdxW-1:0] rsp_host_q;
   logic            any_gnt;
   logic            in_range;
   logic            rsp_valid_q;
   logic            rsp_err_q;
   logic            rsp_fire;
   logic [31:0]     sel_addr;

   // Scan from the round-robin pointer upward; the first requester wins.
   always_comb begin
      any_gnt    = 1'b0;
      gnt_idx    = '0;
      cand       = '0;
      host_gnt_o = '0;
      for (int i = 0; i < NumHosts; i++) begin
         cand = IdxW'((int'(rr_ptr_q) + i) % NumHosts);
         if (!any_gnt && host_req_i[cand]) begin
            any_gnt = 1'b1;
            gnt_idx = cand;
         end
      end
      if (any_gnt) begin
         host_gnt_o[gnt_idx] = 1'b1;
      end
   end

   assign sel_addr = host_addr_i[gnt_idx];
   assign in_range = (sel_addr >> (Aw + 2)) == 32'd0;

   always_comb begin
      ram_req_o   = any_gnt & in_range;
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (ram_req_o) begin
         ram_we_o    = host_we_i[gnt_idx];
         ram_be_o    = host_be_i[gnt_idx];
         ram_addr_o  = sel_addr;
         ram_wdata_o = host_wdata_i[gnt_idx];
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (any_gnt) begin
         if (gnt_idx == IdxW'(NumHosts - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = gnt_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_host_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= any_gnt;
         rsp_host_q  <= gnt_idx;
         rsp_err_q   <= any_gnt & ~in_range;
      end
   end

   // Error responses never touched the RAM, so they fire without ram_rvalid_i.
   assign rsp_fire = rsp_valid_q & (rsp_err_q | ram_rvalid_i);

   always_comb begin
      host_rvalid_o = '0;
      host_err_o    = '0;
      host_rdata_o  = '0;
      for (int h = 0; h < NumHosts; h++) begin
         if (rsp_fire && (rsp_host_q == IdxW'(h))) begin
            host_rvalid_o[h] = 1'b1;
            host_err_o[h]    = rsp_err_q;
            host_rdata_o[h]  = rsp_err_q ? 32'd0 : ram_rdata_i;
         end
      end
   end

   if (NumHosts < 2) begin : g_bad_cfg
      $error("ram_1p_arbiter needs NumHosts >= 2");
   end

   gnt_onehot : assert property (
      @(posedge clk_i) disable iff (!rst_ni) $onehot0(host_gnt_o));

   rsp_has_ram : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (rsp_valid_q && !rsp_err_q) |-> ram_rvalid_i);

endmodule
